// File: rtl/hazard_pkg.sv
// Shared types and constants for the decode-stage hazard scheduler.
// A shadow slot mirrors one in-flight register write: valid, destination, is-load.
package hazard_pkg;

    localparam int SLOT_DST_W = 5;

    typedef struct packed {
        logic                  v;
        logic [SLOT_DST_W-1:0] dst;
        logic                  ld;
    } shadow_slot_t;

    localparam logic [1:0] SLOT_EX  = 2'd0;
    localparam logic [1:0] SLOT_MEM = 2'd1;
    localparam logic [1:0] SLOT_WB  = 2'd2;

    localparam logic [SLOT_DST_W-1:0] REG_ZERO = '0;

    // Register 0 is hardwired, so a write to it can never be a producer.
    function automatic logic slot_match(input shadow_slot_t s, input logic [SLOT_DST_W-1:0] r);
        return s.v && (s.dst == r) && (r != REG_ZERO);
    endfunction

endpackage

// File: rtl/hazard_scheduler_if.sv
// Decode-side bundle between the ID stage and the hazard scheduler.
// HAZARD_STATS_EN adds the stall/flush statistics outputs.
interface hazard_scheduler_if #(parameter int REG_ADDR_W = 5);

    logic                  freeze;
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;
    logic                  id_use_rs;
    logic                  id_use_rt;
    logic                  id_early_use;
    logic                  id_redirect;
    logic                  id_reg_write;
    logic                  id_mem_read;
    logic [REG_ADDR_W-1:0] id_dst;

    logic                  pc_write;
    logic                  ifid_write;
    logic                  ifid_flush;
    logic                  idex_write;
    logic                  idex_bubble;
    logic                  stall;

`ifdef HAZARD_STATS_EN
    logic [31:0]           stall_cnt;
    logic [31:0]           flush_cnt;
    logic [1:0]            max_stall_run;
`endif

    modport master (
        output freeze, id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_early_use,
        output id_redirect, id_reg_write, id_mem_read, id_dst,
        input  pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, stall
`ifdef HAZARD_STATS_EN
        , input stall_cnt, flush_cnt, max_stall_run
`endif
    );

    modport slave (
        input  freeze, id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_early_use,
        input  id_redirect, id_reg_write, id_mem_read, id_dst,
        output pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, stall
`ifdef HAZARD_STATS_EN
        , output stall_cnt, flush_cnt, max_stall_run
`endif
    );

endinterface

// File: rtl/hazard_match.sv
// Per-source hazard detector: does one ID operand depend on an in-flight write
// that cannot yet be delivered to the stage that consumes it?
module hazard_match
    import hazard_pkg::*;
#(
    parameter bit EX_FORWARD = 1'b1,
    parameter bit WB_BYPASS  = 1'b1
) (
    input  shadow_slot_t          i_slot_ex,
    input  shadow_slot_t          i_slot_mem,
    input  shadow_slot_t          i_slot_wb,
    input  logic [SLOT_DST_W-1:0] i_r,
    input  logic                  i_use,
    input  logic                  i_early_use,
    output logic                  o_hz
);

    logic w_m_ex;
    logic w_m_mem;
    logic w_m_wb;
    logic w_unused;

    // Load flags of MEM/WB never matter: their data is already forwardable.
    assign w_unused = &{1'b0, i_slot_mem.ld, i_slot_wb.ld};

    // ID-stage consumers see no forwarding; EX-stage consumers only miss a load still in EX.
    always_comb begin
        w_m_ex  = slot_match(i_slot_ex, i_r);
        w_m_mem = slot_match(i_slot_mem, i_r);
        w_m_wb  = slot_match(i_slot_wb, i_r);
        o_hz    = 1'b0;
        if (i_use) begin
            if (i_early_use || !EX_FORWARD) begin
                o_hz = w_m_ex | w_m_mem | (!WB_BYPASS && w_m_wb);
            end else begin
                o_hz = (w_m_ex & i_slot_ex.ld) | (!WB_BYPASS && w_m_wb);
            end
        end
    end

endmodule

// File: rtl/hazard_scheduler.sv
// Decode-stage hazard scheduler: tracks in-flight writes in a shadow EX/MEM/WB
// pipeline and drives the PC, IF/ID and ID/EX enables, flush and bubble.
// Optional macro HAZARD_STATS_EN adds saturating stall/flush statistics.
module hazard_scheduler
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = SLOT_DST_W,
    parameter bit EX_FORWARD = 1'b1,
    parameter bit WB_BYPASS  = 1'b1
) (
    input logic                Clk,
    input logic                Reset,
    hazard_scheduler_if.slave  bus
);

    shadow_slot_t          r_slot [3];
    shadow_slot_t          w_ex_next;
    logic [REG_ADDR_W-1:0] w_rs;
    logic [REG_ADDR_W-1:0] w_rt;
    logic                  w_use_rs;
    logic                  w_use_rt;
    logic                  w_hz_rs;
    logic                  w_hz_rt;
    logic                  w_stall;
    logic                  w_pc_write;
    logic                  w_ifid_write;
    logic                  w_ifid_flush;
    logic                  w_idex_write;
    logic                  w_idex_bubble;

    assign w_rs     = bus.id_rs;
    assign w_rt     = bus.id_rt;
    assign w_use_rs = bus.id_valid & bus.id_use_rs;
    assign w_use_rt = bus.id_valid & bus.id_use_rt;

    hazard_match #(.EX_FORWARD(EX_FORWARD), .WB_BYPASS(WB_BYPASS)) u_match_rs (
        .i_slot_ex   (r_slot[SLOT_EX]),
        .i_slot_mem  (r_slot[SLOT_MEM]),
        .i_slot_wb   (r_slot[SLOT_WB]),
        .i_r         (w_rs),
        .i_use       (w_use_rs),
        .i_early_use (bus.id_early_use),
        .o_hz        (w_hz_rs)
    );

    hazard_match #(.EX_FORWARD(EX_FORWARD), .WB_BYPASS(WB_BYPASS)) u_match_rt (
        .i_slot_ex   (r_slot[SLOT_EX]),
        .i_slot_mem  (r_slot[SLOT_MEM]),
        .i_slot_wb   (r_slot[SLOT_WB]),
        .i_r         (w_rt),
        .i_use       (w_use_rt),
        .i_early_use (bus.id_early_use),
        .o_hz        (w_hz_rt)
    );

    assign w_stall = w_hz_rs | w_hz_rt;

    // What ID hands to EX next edge; a stalled instruction becomes a bubble. A jal's $31 write
    // survives a redirect because only IF/ID is flushed.
    always_comb begin
        w_ex_next.v   = bus.id_valid & bus.id_reg_write & (bus.id_dst != REG_ZERO) & ~w_stall;
        w_ex_next.dst = bus.id_dst;
        w_ex_next.ld  = bus.id_mem_read;
    end

    // Shadow pipeline advances with the real pipeline and holds under freeze.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < 3; i++) begin
                r_slot[i] <= '0;
            end
        end else if (!bus.freeze) begin
            r_slot[SLOT_WB]  <= r_slot[SLOT_MEM];
            r_slot[SLOT_MEM] <= r_slot[SLOT_EX];
            r_slot[SLOT_EX]  <= w_ex_next;
        end
    end

    // Freeze beats stall beats redirect; a redirect seen while stalled is re-resolved later.
    always_comb begin
        w_pc_write    = 1'b1;
        w_ifid_write  = 1'b1;
        w_idex_write  = 1'b1;
        w_ifid_flush  = 1'b0;
        w_idex_bubble = 1'b0;
        if (bus.freeze) begin
            w_pc_write   = 1'b0;
            w_ifid_write = 1'b0;
            w_idex_write = 1'b0;
        end else if (w_stall) begin
            w_pc_write    = 1'b0;
            w_ifid_write  = 1'b0;
            w_idex_bubble = 1'b1;
        end else begin
            w_ifid_flush = bus.id_valid & bus.id_redirect;
        end
    end

    assign bus.pc_write    = w_pc_write;
    assign bus.ifid_write  = w_ifid_write;
    assign bus.ifid_flush  = w_ifid_flush;
    assign bus.idex_write  = w_idex_write;
    assign bus.idex_bubble = w_idex_bubble;
    assign bus.stall       = w_stall;

`ifdef HAZARD_STATS_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;
    logic [1:0]  r_run;
    logic [1:0]  r_max_run;
    logic [1:0]  w_run_inc;

    assign w_run_inc = (r_run == 2'd3) ? 2'd3 : r_run + 2'd1;

    // Saturating statistics; a frozen cycle neither extends nor breaks a stall run.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
            r_run       <= '0;
            r_max_run   <= '0;
        end else begin
            if (w_stall && !bus.freeze && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (w_ifid_flush && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
            if (!bus.freeze) begin
                if (w_stall) begin
                    r_run <= w_run_inc;
                    if (w_run_inc > r_max_run) begin
                        r_max_run <= w_run_inc;
                    end
                end else begin
                    r_run <= '0;
                end
            end
        end
    end

    assign bus.stall_cnt     = r_stall_cnt;
    assign bus.flush_cnt     = r_flush_cnt;
    assign bus.max_stall_run = r_max_run;
`endif

endmodule
